uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 174 +++++++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// AXI-stream style payload handshake into the UART transmitter.
// The master drives data/valid, and the transmitter answers with ready.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, optional parity,
// 1 or 2 stop bits; each bit lasts 8*prescale clocks.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_tx_if.slave    s_axis,
    output logic        txd,
    output logic        busy,
    input  logic [15:0] prescale,
    input  logic [1:0]  parity_mode,
    input  logic        two_stop
);
    localparam int CW = 19;
    localparam int BW = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  tready_q, tready_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         period_q, period_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_left_q, stop_left_d;

    logic [15:0]   p_eff;
    logic [CW-1:0] hs_period;
    logic          bit_end;
    logic          hs;

    // A prescale of zero would give a zero-length bit, so clamp to one.
    assign p_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
    assign hs_period = {p_eff, 3'b000};
    assign bit_end   = (cnt_q == '0);
    assign hs        = s_axis.s_axis_tvalid && tready_q;

    always_comb begin
        state_d     = state_q;
        txd_d       = txd_q;
        busy_d      = busy_q;
        tready_d    = tready_q;
        shreg_d     = shreg_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        two_stop_d  = two_stop_q;
        stop_left_d = stop_left_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? (period_q - 19'd1) : (cnt_q - 19'd1);
        end

        unique case (state_q)
            IDLE: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                if (hs) begin
                    state_d    = START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    tready_d   = 1'b0;
                    shreg_d    = s_axis.s_axis_tdata;
                    period_d   = hs_period;
                    cnt_d      = hs_period - 19'd1;
                    par_en_d   = ^parity_mode;
                    par_bit_d  = (^s_axis.s_axis_tdata)
                               ^ (parity_mode == 2'b10);
                    two_stop_d = two_stop;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = BW'(DATA_WIDTH);
                    txd_d     = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BW'(1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d     = STOP;
                            txd_d       = 1'b1;
                            stop_left_d = two_stop_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        shreg_d   = shreg_q >> 1;
                        txd_d     = shreg_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d     = STOP;
                    txd_d       = 1'b1;
                    stop_left_d = two_stop_q;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_left_q) begin
                        stop_left_d = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        txd_d    = 1'b1;
                        busy_d   = 1'b0;
                        tready_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            tready_q    <= 1'b1;
            shreg_q     <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_left_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            tready_q    <= tready_d;
            shreg_q     <= shreg_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            two_stop_q  <= two_stop_d;
            stop_left_q <= stop_left_d;
        end
    end

    assign txd                  = txd_q;
    assign busy                 = busy_q;
    assign s_axis.s_axis_tready = tready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, parity, stop bits,
// back-to-back, mid-frame input changes and reset abort.
module tb_uart_tx;
    logic        clk;
    logic        rst_n;
    logic        txd;
    logic        busy;
    logic [15:0] prescale;
    logic [1:0]  parity_mode;
    logic        two_stop;

    int checks;
    int errors;

    uart_tx_if #(.DATA_WIDTH(8)) axis ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_axis      (axis.slave),
        .txd         (txd),
        .busy        (busy),
        .prescale    (prescale),
        .parity_mode (parity_mode),
        .two_stop    (two_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [15:0] p,
                         input logic [1:0] pm, input logic ts);
        axis.s_axis_tdata  = d;
        axis.s_axis_tvalid = 1'b1;
        prescale           = p;
        parity_mode        = pm;
        two_stop           = ts;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_txd"},    {31'd0, txd},                1);
        chk({tag, "_busy"},   {31'd0, busy},               0);
        chk({tag, "_tready"}, {31'd0, axis.s_axis_tready}, 1);
    endtask

    // Called at a negedge with inputs already driven; ends at the
    // negedge of the first idle cycle after the frame.
    task automatic run_frame(input string tag, input int period,
                             input int nbits, input logic [11:0] exp,
                             input bit hold, input bit chg,
                             input logic [7:0] chg_d,
                             input logic [15:0] chg_p);
        int bad;
        int busy_cnt;
        chk({tag, "_ready"}, {31'd0, axis.s_axis_tready}, 1);
        @(posedge clk);
        #1;
        if (!hold) axis.s_axis_tvalid = 1'b0;
        busy_cnt = 0;
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int c = 0; c < period; c++) begin
                @(negedge clk);
                if (txd !== exp[b]) bad++;
                if (busy === 1'b1) busy_cnt++;
                if (chg && b == 2 && c == 0) begin
                    axis.s_axis_tdata = chg_d;
                    prescale          = chg_p;
                end
            end
            chk($sformatf("%s_bit%0d_badcycles", tag, b), bad, 0);
        end
        chk({tag, "_busycycles"}, busy_cnt, nbits * period);
        @(negedge clk);
        chk_idle({tag, "_end"});
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        axis.s_axis_tdata  = 8'h00;
        axis.s_axis_tvalid = 1'b0;
        prescale           = 16'd1;
        parity_mode        = 2'b00;
        two_stop           = 1'b0;

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        drive(8'hA5, 16'd1, 2'b00, 1'b0);
        run_frame("8n1", 8, 10, 12'b00_1101001010, 0, 0, 8'h00, 16'd0);

        // even parity of 0xA5 is 0
        drive(8'hA5, 16'd2, 2'b01, 1'b0);
        run_frame("even", 16, 11, 12'b0_10101001010, 0, 0, 8'h00, 16'd0);

        // odd parity of 0xA5 is 1
        drive(8'hA5, 16'd2, 2'b10, 1'b0);
        run_frame("odd", 16, 11, 12'b0_11101001010, 0, 0, 8'h00, 16'd0);

        // 0xFF, two stop bits
        drive(8'hFF, 16'd1, 2'b00, 1'b1);
        run_frame("2stop", 8, 11, 12'b0_11111111110, 0, 0, 8'h00, 16'd0);

        // back-to-back 0x01 then 0x80 with valid held high
        drive(8'h01, 16'd1, 2'b00, 1'b0);
        run_frame("b2b_a", 8, 10, 12'b00_1000000010, 1, 0, 8'h00, 16'd0);
        axis.s_axis_tdata = 8'h80;
        run_frame("b2b_b", 8, 10, 12'b00_1100000000, 0, 0, 8'h00, 16'd0);

        // 0x5A with prescale/tdata changed mid-frame, then 0xC3 at 4
        drive(8'h5A, 16'd1, 2'b00, 1'b0);
        run_frame("chg_a", 8, 10, 12'b00_1010110100, 1, 1, 8'h00, 16'd4);
        axis.s_axis_tvalid = 1'b0;
        @(negedge clk);
        drive(8'hC3, 16'd4, 2'b00, 1'b0);
        run_frame("chg_b", 32, 10, 12'b00_1110000110, 0, 0, 8'h00, 16'd0);

        // prescale 0 acts as 1, parity mode 11 acts as none
        drive(8'h33, 16'd0, 2'b11, 1'b0);
        run_frame("p0_pm3", 8, 10, 12'b00_1001100110, 0, 0, 8'h00, 16'd0);

        // reset during data bit 3 of 0x00
        drive(8'h00, 16'd1, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        axis.s_axis_tvalid = 1'b0;
        repeat (36) @(negedge clk);
        chk("rst_bit3_txd", {31'd0, txd}, 0);
        chk("rst_bit3_busy", {31'd0, busy}, 1);
        rst_n              = 1'b0;
        axis.s_axis_tvalid = 1'b1;
        axis.s_axis_tdata  = 8'h55;
        @(negedge clk);
        chk_idle("rst_abort");
        @(negedge clk);
        chk_idle("rst_no_hs");
        axis.s_axis_tvalid = 1'b0;
        rst_n              = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("rst_release");

        drive(8'h3C, 16'd1, 2'b00, 1'b0);
        run_frame("after_rst", 8, 10, 12'b00_1001111000, 0, 0, 8'h00, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
